// File: rtl/redmule_mx_slot_arbiter_pkg.sv
// MX slot arbiter shared types.
// Stream select enum and exponent lane helpers.
package redmule_mx_slot_arbiter_pkg;

  typedef enum logic {
    MX_SEL_X = 1'b0,
    MX_SEL_W = 1'b1
  } mx_arb_sel_e;

  localparam int unsigned MX_EXP_LANE_W = 8;

  function automatic int unsigned mx_exp_rep(
    input int unsigned vec_w
  );
    return vec_w / MX_EXP_LANE_W;
  endfunction

endpackage

// File: rtl/redmule_mx_slot_arbiter_if.sv
// Decoder-facing valid/ready stream.
// Carries one MX slot tagged X or W.
interface redmule_mx_slot_arbiter_if #(
  parameter int unsigned MX_DATA_W       = 256,
  parameter int unsigned MX_EXP_VECTOR_W = 32
);

  logic                       valid;
  logic                       ready;
  logic [MX_DATA_W-1:0]       data;
  logic [MX_EXP_VECTOR_W-1:0] exp;
  logic                       is_w;

  modport master (
    output valid,
    output data,
    output exp,
    output is_w,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  exp,
    input  is_w,
    output ready
  );

endinterface

// File: rtl/redmule_mx_slot_arbiter.sv
// Weighted round-robin X/W slot arbiter.
// Feeds one registered MX decode stage.
module redmule_mx_slot_arbiter
  import redmule_mx_slot_arbiter_pkg::*;
#(
  parameter int unsigned MX_DATA_W       = 256,
  parameter int unsigned MX_EXP_VECTOR_W = 32,
  parameter int unsigned W_PER_X         = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       mx_enable_i,
  input  logic                       x_slot_valid_i,
  input  logic [MX_DATA_W-1:0]       x_slot_data_i,
  input  logic [7:0]                 x_slot_exp_i,
  input  logic                       w_slot_valid_i,
  input  logic [MX_DATA_W-1:0]       w_slot_data_i,
  input  logic [MX_EXP_VECTOR_W-1:0] w_slot_exp_i,
  output logic                       consume_x_slot_o,
  output logic                       consume_w_slot_o,
  redmule_mx_slot_arbiter_if.master  dec
);

  localparam int unsigned EXP_REP = mx_exp_rep(MX_EXP_VECTOR_W);
  localparam int unsigned CNT_W   = $clog2(W_PER_X + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W_PER_X - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mx_arb_sel_e pref_q, pref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_en;
  logic gnt_x;
  logic gnt_w;

  logic                       out_valid_q;
  logic [MX_DATA_W-1:0]       out_data_q;
  logic [MX_EXP_VECTOR_W-1:0] out_exp_q;
  logic                       out_is_w_q;

  assign load_en = mx_enable_i & ~clear_i &
                   (~out_valid_q | dec.ready);

  // Preferred stream first, other stream as fallback.
  always_comb begin
    gnt_x = 1'b0;
    gnt_w = 1'b0;
    if (load_en) begin
      unique case (pref_q)
        MX_SEL_X: begin
          if (x_slot_valid_i)      gnt_x = 1'b1;
          else if (w_slot_valid_i) gnt_w = 1'b1;
        end
        MX_SEL_W: begin
          if (w_slot_valid_i)      gnt_w = 1'b1;
          else if (x_slot_valid_i) gnt_x = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Preference update; fallback grants leave it alone.
  always_comb begin
    pref_d = pref_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      clear_i: begin
        pref_d = MX_SEL_X;
        cnt_d  = '0;
      end
      (gnt_x && pref_q == MX_SEL_X): begin
        pref_d = MX_SEL_W;
        cnt_d  = '0;
      end
      (gnt_w && pref_q == MX_SEL_W): begin
        if (cnt_q == CNT_LAST) begin
          pref_d = MX_SEL_X;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  // Preference state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pref_q <= MX_SEL_X;
      cnt_q  <= '0;
    end else begin
      pref_q <= pref_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output stage: load on grant, drain on ready.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_exp_q   <= '0;
      out_is_w_q  <= 1'b0;
    end else if (clear_i) begin
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= gnt_x | gnt_w;
      if (gnt_x) begin
        out_data_q <= x_slot_data_i;
        out_exp_q  <= {EXP_REP{x_slot_exp_i}};
        out_is_w_q <= 1'b0;
      end else if (gnt_w) begin
        out_data_q <= w_slot_data_i;
        out_exp_q  <= w_slot_exp_i;
        out_is_w_q <= 1'b1;
      end
    end else if (dec.ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign consume_x_slot_o = gnt_x;
  assign consume_w_slot_o = gnt_w;

  assign dec.valid = out_valid_q;
  assign dec.data  = out_data_q;
  assign dec.exp   = out_exp_q;
  assign dec.is_w  = out_is_w_q;

endmodule

// File: tb/tb_redmule_mx_slot_arbiter.sv
// Bench for the MX slot arbiter.
// Two instances (W_PER_X 1 and 3) against a turn-based model.
module tb_redmule_mx_slot_arbiter;

  localparam int DW = 256;
  localparam int EW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clear, en, xv, wv, rdy;
  logic [DW-1:0] xd, wd;
  logic [7:0]    xe;
  logic [EW-1:0] we;
  logic          cx [2];
  logic          cw [2];

  redmule_mx_slot_arbiter_if #(.MX_DATA_W(DW), .MX_EXP_VECTOR_W(EW)) dec0 ();
  redmule_mx_slot_arbiter_if #(.MX_DATA_W(DW), .MX_EXP_VECTOR_W(EW)) dec1 ();

  assign dec0.ready = rdy;
  assign dec1.ready = rdy;

  redmule_mx_slot_arbiter #(
    .MX_DATA_W(DW), .MX_EXP_VECTOR_W(EW), .W_PER_X(1)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .mx_enable_i(en),
    .x_slot_valid_i(xv), .x_slot_data_i(xd),
    .x_slot_exp_i(xe),
    .w_slot_valid_i(wv), .w_slot_data_i(wd),
    .w_slot_exp_i(we),
    .consume_x_slot_o(cx[0]), .consume_w_slot_o(cw[0]),
    .dec(dec0)
  );

  redmule_mx_slot_arbiter #(
    .MX_DATA_W(DW), .MX_EXP_VECTOR_W(EW), .W_PER_X(3)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .mx_enable_i(en),
    .x_slot_valid_i(xv), .x_slot_data_i(xd),
    .x_slot_exp_i(xe),
    .w_slot_valid_i(wv), .w_slot_data_i(wd),
    .w_slot_exp_i(we),
    .consume_x_slot_o(cx[1]), .consume_w_slot_o(cw[1]),
    .dec(dec1)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: after a preferred X grant, W owns the next W_PER_X turns.
  int            wpx [2] = '{1, 3};
  int            wl  [2];
  logic          mv  [2];
  logic [DW-1:0] md  [2];
  logic [EW-1:0] me  [2];
  logic          mw  [2];

  task automatic check(string tag, logic [DW-1:0] obs,
                       logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      wl[k] = 0; mv[k] = 1'b0; md[k] = '0;
      me[k] = '0; mw[k] = 1'b0;
    end
  endtask

  task automatic eval(int k, logic cxo, logic cwo, logic v,
                      logic [DW-1:0] d, logic [EW-1:0] e,
                      logic iw);
    logic ld, pw, gx, gw;
    ld = en & ~clear & (~mv[k] | rdy);
    pw = (wl[k] > 0);
    gx = ld & xv & (~pw | ~wv);
    gw = ld & wv & ~gx;
    check($sformatf("valid%0d", k), DW'(v), DW'(mv[k]));
    if (mv[k]) begin
      check($sformatf("data%0d", k), d, md[k]);
      check($sformatf("exp%0d", k), DW'(e), DW'(me[k]));
      check($sformatf("is_w%0d", k), DW'(iw), DW'(mw[k]));
    end
    if (rst_n) begin
      check($sformatf("cons_x%0d", k), DW'(cxo), DW'(gx));
      check($sformatf("cons_w%0d", k), DW'(cwo), DW'(gw));
    end
    if (!rst_n) begin
      wl[k] = 0; mv[k] = 1'b0; md[k] = '0;
      me[k] = '0; mw[k] = 1'b0;
    end else if (clear) begin
      mv[k] = 1'b0; wl[k] = 0;
    end else if (ld) begin
      mv[k] = gx | gw;
      if (gx) begin
        md[k] = xd; me[k] = {4{xe}}; mw[k] = 1'b0;
        if (!pw) wl[k] = wpx[k];
      end
      if (gw) begin
        md[k] = wd; me[k] = we; mw[k] = 1'b1;
        if (pw) wl[k] = wl[k] - 1;
      end
    end else if (rdy) begin
      mv[k] = 1'b0;
    end
  endtask

  task automatic rnd_data();
    for (int i = 0; i < DW / 32; i++) begin
      xd[i*32 +: 32] = $urandom;
      wd[i*32 +: 32] = $urandom;
    end
    xe = 8'($urandom);
    we = $urandom;
  endtask

  task automatic cyc();
    #1;
    eval(0, cx[0], cw[0], dec0.valid, dec0.data,
         dec0.exp, dec0.is_w);
    eval(1, cx[1], cw[1], dec1.valid, dec1.data,
         dec1.exp, dec1.is_w);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(int n, logic x, logic w, logic r);
    for (int i = 0; i < n; i++) begin
      rnd_data();
      xv = x; wv = w; rdy = r;
      cyc();
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; en = 1'b0;
    xv = 1'b0; wv = 1'b0; rdy = 1'b0;
    rnd_data();
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    #1;
    check("rst_valid", DW'(dec0.valid), '0);
    check("rst_data", dec0.data, '0);
    check("rst_exp", DW'(dec1.exp), '0);
    check("rst_is_w", DW'(dec1.is_w), '0);
    check("rst_cons", DW'({cx[0], cw[0], cx[1], cw[1]}), '0);
    rst_n = 1'b1; en = 1'b1;
    run(2, 1'b0, 1'b0, 1'b1);

    run(16, 1'b1, 1'b1, 1'b1);

    clear = 1'b1;
    run(1, 1'b1, 1'b1, 1'b1);
    clear = 1'b0;
    run(5, 1'b0, 1'b1, 1'b1);
    rnd_data();
    xv = 1'b1; wv = 1'b1; rdy = 1'b1;
    #1;
    check("fb_then_x0", DW'(cx[0]), DW'(1));
    check("fb_then_x1", DW'(cx[1]), DW'(1));
    cyc();

    run(3, 1'b1, 1'b1, 1'b1);
    run(4, 1'b1, 1'b1, 1'b0);
    run(4, 1'b1, 1'b1, 1'b1);

    clear = 1'b1;
    run(1, 1'b0, 1'b0, 1'b1);
    clear = 1'b0;
    rnd_data();
    xe = 8'h7F; xv = 1'b1; wv = 1'b0; rdy = 1'b1;
    cyc();
    #1;
    check("exp_rep", DW'(dec0.exp), DW'(32'h7F7F7F7F));
    check("exp_is_w", DW'(dec0.is_w), '0);

    run(3, 1'b1, 1'b1, 1'b1);
    run(2, 1'b1, 1'b1, 1'b0);
    clear = 1'b1;
    rnd_data(); xv = 1'b1; wv = 1'b1; rdy = 1'b1;
    cyc();
    clear = 1'b0;
    run(4, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    run(1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    run(4, 1'b1, 1'b1, 1'b1);

    run(2, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    run(2, 1'b1, 1'b1, 1'b0);
    run(3, 1'b1, 1'b1, 1'b1);
    en = 1'b1;
    run(4, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      rnd_data();
      xv    = ($urandom_range(0, 99) < 60);
      wv    = ($urandom_range(0, 99) < 70);
      rdy   = ($urandom_range(0, 99) < 70);
      en    = ($urandom_range(0, 99) < 92);
      clear = ($urandom_range(0, 99) < 3);
      rst_n = ($urandom_range(0, 999) >= 4);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
